// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types and defaults for the LSU data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_mem_arbiter_pkg;

    // Default geometry of the arbiter
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 8;

    // Arbiter FSM states, 3-bit encoded
    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAITING   = 3'd1,
        ST_WRITE_WAITING  = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } arb_state_e;

endpackage

// File: rtl/lsu_mem_arbiter_rr_pick.sv
// Round-robin picker: first active requester after last_grant, wrapping mod NUM_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;

    // Walk last_grant+1 .. last_grant+NUM_REQ and keep the first active index
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one read/write data-memory channel among NUM_REQ LSUs, round-robin, one transaction at a time.
// Latency: mem_*_valid one cycle after a request is seen; req ready one cycle after mem ready.
// Backpressure: requesters wait on req_*_ready; memory stalls by holding mem_*_ready low.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_read_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_read_address,
    output logic [NUM_REQ-1:0]             req_read_ready,
    output logic [NUM_REQ*DATA_BITS-1:0]   req_read_data,
    input  logic [NUM_REQ-1:0]             req_write_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_write_address,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]             req_write_ready,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready,
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             g_q, g_d;
    logic [IDX_W-1:0]             last_grant_q, last_grant_d;
    logic [ADDR_BITS-1:0]         rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]         wr_data_q, wr_data_d;
    logic [NUM_REQ*DATA_BITS-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]             pick_idx;
    logic                         any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_read_valid | req_write_valid),
        .last_grant (last_grant_q),
        .grant      (pick_idx),
        .any_req    (any_req)
    );

    // State register; reset aborts any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant in IDLE, wait for memory, then hold until the requester lets go
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = req_read_valid[pick_idx] ? ST_READ_WAITING : ST_WRITE_WAITING;
                end
            end
            ST_READ_WAITING:   if (mem_read_ready)          state_d = ST_READ_RELAYING;
            ST_WRITE_WAITING:  if (mem_write_ready)         state_d = ST_WRITE_RELAYING;
            ST_READ_RELAYING:  if (!req_read_valid[g_q])    state_d = ST_IDLE;
            ST_WRITE_RELAYING: if (!req_write_valid[g_q])   state_d = ST_IDLE;
            default:                                        state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch the granted request, capture read data on completion
    always_comb begin
        g_d          = g_q;
        last_grant_d = last_grant_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rdata_d      = rdata_q;
        if (state_q == ST_IDLE && any_req) begin
            g_d          = pick_idx;
            last_grant_d = pick_idx;
            if (req_read_valid[pick_idx]) begin
                rd_addr_d = req_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
            end else begin
                wr_addr_d = req_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                wr_data_d = req_write_data[pick_idx*DATA_BITS +: DATA_BITS];
            end
        end
        if (state_q == ST_READ_WAITING && mem_read_ready) begin
            rdata_d[g_q*DATA_BITS +: DATA_BITS] = mem_read_data;
        end
    end

    // Datapath registers; last_grant resets to NUM_REQ-1 so requester 0 is searched first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q          <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rdata_q      <= '0;
        end else begin
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode from registered state only, so they clear as soon as reset asserts
    always_comb begin
        mem_read_valid    = (state_q == ST_READ_WAITING);
        mem_write_valid   = (state_q == ST_WRITE_WAITING);
        mem_read_address  = rd_addr_q;
        mem_write_address = wr_addr_q;
        mem_write_data    = wr_data_q;
        req_read_data     = rdata_q;
        busy              = (state_q != ST_IDLE);
        req_read_ready    = '0;
        req_write_ready   = '0;
        if (state_q == ST_READ_RELAYING)  req_read_ready[g_q]  = 1'b1;
        if (state_q == ST_WRITE_RELAYING) req_write_ready[g_q] = 1'b1;
    end

endmodule
